clksel_requester: RTL and testbench

- Initiator-side controller for the clock-switcher select channel (clksel_val/clksel_rdy/clksel_msg).
- Accepts clock-select commands from the configuration/DVFS logic and turns them into switcher transactions.
- Suppresses redundant requests and enforces a minimum dwell time between switches.
- Reports the current selection, a switch count and a sticky timeout error; sits beside each rgals tile wrapper on the always-on clock.

---
 rtl/rgals_pkg.sv | 15 +
 rtl/clksel_dwell_counter.sv | 42 ++++
 rtl/clksel_requester.sv | 129 ++++++++++++
 tb/tb_clksel_requester.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgals_pkg.sv
// Shared definitions for the rgals clock-select controller.
//   state_e      : requester FSM states
//   CLKSEL_CLK1/2: encodings of the select message (clk1 is the reset clock)
package rgals_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DWELL = 2'd2
  } state_e;

  localparam logic CLKSEL_CLK1 = 1'b0;
  localparam logic CLKSEL_CLK2 = 1'b1;

endpackage

// File: rtl/clksel_dwell_counter.sv
// Loadable counter with a terminal value, used both for the post-switch
// dwell (down mode, terminal 0) and the request timeout (up mode,
// terminal p_limit, saturating).
// Ports:
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over en)
//   load_val   : value to load
//   en         : step one count toward the terminal value
//   done       : count currently equals the terminal value
//   arrive     : this cycle's step lands on the terminal value
module clksel_dwell_counter #(
  parameter int p_width = 8,
  parameter bit p_up    = 1'b0,
  parameter int p_limit = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [p_width-1:0] load_val,
  input  logic               en,
  output logic               done,
  output logic               arrive
);

  localparam logic [p_width-1:0] TERM = p_up ? p_width'(p_limit) : '0;

  logic [p_width-1:0] cnt;
  logic [p_width-1:0] step;

  assign step   = p_up ? cnt + 1'b1 : cnt - 1'b1;
  assign done   = (cnt == TERM);
  // Only counts as an arrival when a real step happens, so a saturated
  // counter does not keep re-arriving.
  assign arrive = en && !load && !done && (step == TERM);

  always_ff @(posedge clk) begin
    if (reset)            cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (en && !done) cnt <= step;
  end

endmodule

// File: rtl/clksel_requester.sv
// Initiator-side controller for the clock-switcher select channel.
// Takes clock-select commands, drops requests for the clock already in use,
// issues one switcher transaction per real change, then holds off new
// commands for p_dwell cycles counted from the handshake cycle.
// Ports:
//   clk, reset             : always-on clock, synchronous active-high reset
//   cmd_val/cmd_rdy/cmd_msg: command input (msg 0 = clk1, 1 = clk2)
//   clksel_val/rdy/msg     : request to the clock switcher
//   cur_sel                : clock selected by the last completed handshake
//   busy                   : a switch or its dwell is in progress
//   sw_count               : completed switches, wrapping
//   err                    : sticky, request waited too long for clksel_rdy
module clksel_requester
  import rgals_pkg::*;
#(
  parameter int p_dwell     = 16,
  parameter int p_timeout   = 64,
  parameter int p_cnt_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_val,
  output logic                   cmd_rdy,
  input  logic                   cmd_msg,
  output logic                   clksel_val,
  input  logic                   clksel_rdy,
  output logic                   clksel_msg,
  output logic                   cur_sel,
  output logic                   busy,
  output logic [p_cnt_width-1:0] sw_count,
  output logic                   err
);

  localparam int DW = 8;   // holds p_dwell-1 up to 254
  localparam int TW = 10;  // holds p_timeout-1 up to 1022

  state_e state, state_n;
  logic   tgt;
  logic   accept, handshake;
  logic   wait_step;
  logic   dwell_done, dwell_arrive;
  logic   to_done, to_arrive;

  // Dwell: loaded with p_dwell-1 on the handshake; the step that lands on
  // zero is the last busy cycle, so IDLE returns p_dwell cycles after the
  // handshake. p_dwell=1 skips DWELL entirely.
  clksel_dwell_counter #(
    .p_width (DW),
    .p_up    (1'b0),
    .p_limit (0)
  ) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load     (handshake),
    .load_val (DW'(p_dwell - 1)),
    .en       (state == DWELL),
    .done     (dwell_done),
    .arrive   (dwell_arrive)
  );

  // Timeout: cleared on acceptance, counts ISSUE cycles without clksel_rdy;
  // reaching p_timeout-1 raises err. It saturates there, request stays up.
  assign wait_step = (state == ISSUE) && !clksel_rdy;

  clksel_dwell_counter #(
    .p_width (TW),
    .p_up    (1'b1),
    .p_limit (p_timeout - 1)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val ('0),
    .en       (wait_step),
    .done     (to_done),
    .arrive   (to_arrive)
  );

  always_comb begin
    state_n    = state;
    cmd_rdy    = 1'b0;
    clksel_val = 1'b0;
    accept     = 1'b0;
    handshake  = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_rdy = 1'b1;
        // A command for the clock already selected is consumed silently.
        if (cmd_val && (cmd_msg != cur_sel)) begin
          accept  = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        clksel_val = 1'b1;
        if (clksel_rdy) begin
          handshake = 1'b1;
          state_n   = (p_dwell == 1) ? IDLE : DWELL;
        end
      end
      DWELL: begin
        if (dwell_arrive || dwell_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tgt      <= CLKSEL_CLK1;
      cur_sel  <= CLKSEL_CLK1;
      sw_count <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) tgt <= cmd_msg;
      if (handshake) begin
        cur_sel  <= tgt;
        sw_count <= sw_count + 1'b1;
      end
      if (wait_step && (to_arrive || to_done)) err <= 1'b1;
    end
  end

  assign clksel_msg = tgt;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_clksel_requester.sv
// Self-checking bench for clksel_requester: a cycle-level behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
// A second instance with a 2-bit counter shares the stimulus to exercise
// sw_count wrap-around.
module tb_clksel_requester;

  localparam int DWELL = 16;
  localparam int TMO   = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_val = 1'b0;
  logic       cmd_msg = 1'b0;
  logic       clksel_rdy = 1'b0;
  logic       cmd_rdy, clksel_val, clksel_msg, cur_sel, busy, err;
  logic [7:0] sw_count;
  logic       cmd_rdy2, clksel_val2, clksel_msg2, cur_sel2, busy2, err2;
  logic [1:0] sw_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clksel_requester #(.p_dwell(DWELL), .p_timeout(TMO), .p_cnt_width(8)) dut (
    .clk(clk), .reset(reset), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_msg(cmd_msg),
    .clksel_val(clksel_val), .clksel_rdy(clksel_rdy), .clksel_msg(clksel_msg),
    .cur_sel(cur_sel), .busy(busy), .sw_count(sw_count), .err(err)
  );

  clksel_requester #(.p_dwell(DWELL), .p_timeout(TMO), .p_cnt_width(2)) dut2 (
    .clk(clk), .reset(reset), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy2), .cmd_msg(cmd_msg),
    .clksel_val(clksel_val2), .clksel_rdy(clksel_rdy), .clksel_msg(clksel_msg2),
    .cur_sel(cur_sel2), .busy(busy2), .sw_count(sw_count2), .err(err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pend: a request is outstanding; hold: busy cycles left after a switch;
  // waited: cycles the outstanding request has gone unanswered.
  bit m_ok = 0, m_pend = 0, m_tgt = 0, m_cur = 0, m_err = 0;
  int m_cnt = 0, m_hold = 0, m_waited = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1; m_pend = 0; m_tgt = 0; m_cur = 0; m_err = 0;
      m_cnt = 0; m_hold = 0; m_waited = 0;
    end else if (m_ok) begin
      if (m_pend) begin
        if (clksel_rdy) begin
          m_cur  = m_tgt;
          m_cnt  = m_cnt + 1;
          m_pend = 0;
          m_hold = DWELL - 1;
        end else begin
          m_waited = m_waited + 1;
          if (m_waited >= TMO - 1) m_err = 1;
        end
      end else if (m_hold > 0) begin
        m_hold = m_hold - 1;
      end else if (cmd_val && cmd_msg != m_cur) begin
        m_pend = 1; m_tgt = cmd_msg; m_waited = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cmd_rdy",    cmd_rdy,    (!m_pend && m_hold == 0));
      chk("busy",       busy,       (m_pend || m_hold != 0));
      chk("clksel_val", clksel_val, m_pend);
      if (m_pend) chk("clksel_msg", clksel_msg, m_tgt);
      chk("cur_sel",    cur_sel,    m_cur);
      chk("sw_count",   sw_count,   m_cnt % 256);
      chk("err",        err,        m_err);
      chk("sw_count2",  sw_count2,  m_cnt % 4);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!cmd_rdy && n < 200) begin
      step();
      n++;
    end
    if (!cmd_rdy) chk("wait_idle_timeout", 0, 1);
  endtask

  initial begin
    int n;
    bit seq [3];
    seq[0] = 1; seq[1] = 0; seq[2] = 1;

    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_val", clksel_val, 0);
    chk("rst_cur", cur_sel, 0);
    chk("rst_sw", sw_count, 0);
    chk("rst_err", err, 0);

    // Switch to clk2, switcher always ready: one-cycle request, dwell 16.
    clksel_rdy = 1'b1;
    cmd_msg = 1'b1; cmd_val = 1'b1;
    step();
    cmd_val = 1'b0;
    chk("t1_val", clksel_val, 1);
    chk("t1_msg", clksel_msg, 1);
    chk("t1_cur_before", cur_sel, 0);
    step();
    chk("t1_val_drop", clksel_val, 0);
    chk("t1_cur", cur_sel, 1);
    chk("t1_sw", sw_count, 1);
    chk("t1_busy", busy, 1);
    wait_idle(n);
    chk("t1_dwell_len", n, DWELL - 1);

    // Redundant command (already on clk2) is consumed as a no-op.
    cmd_msg = 1'b1; cmd_val = 1'b1;
    step();
    cmd_val = 1'b0;
    chk("t2a_busy", busy, 0);
    chk("t2a_val", clksel_val, 0);
    chk("t2a_sw", sw_count, 1);

    // Timeout: switcher withholds rdy for 70 cycles.
    clksel_rdy = 1'b0;
    cmd_msg = 1'b0; cmd_val = 1'b1;
    step();
    cmd_val = 1'b0;
    repeat (62) step();
    chk("t3_err_early", err, 0);
    step();
    chk("t3_err_set", err, 1);
    repeat (7) step();
    chk("t3_val_held", clksel_val, 1);
    chk("t3_msg_held", clksel_msg, 0);
    clksel_rdy = 1'b1;
    step();
    chk("t3_cur", cur_sel, 0);
    chk("t3_err_sticky", err, 1);
    chk("t3_sw", sw_count, 2);

    // Back-to-back commands with cmd_val held high.
    for (int i = 0; i < 3; i++) begin
      cmd_msg = seq[i]; cmd_val = 1'b1;
      wait_idle(n);
      step();
    end
    cmd_val = 1'b0;
    wait_idle(n);
    chk("t4_cur", cur_sel, 1);
    chk("t4_sw", sw_count, 5);
    chk("t6_sw_wrap", sw_count2, 1);

    // Reset during ISSUE.
    clksel_rdy = 1'b0;
    cmd_msg = 1'b0; cmd_val = 1'b1;
    step();
    cmd_val = 1'b0;
    repeat (3) step();
    chk("t5a_in_issue", clksel_val, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5a_val", clksel_val, 0);
    chk("t5a_cur", cur_sel, 0);
    chk("t5a_busy", busy, 0);
    chk("t5a_sw", sw_count, 0);
    chk("t5a_err", err, 0);

    // From clk1, a clk1 command does nothing.
    cmd_msg = 1'b0; cmd_val = 1'b1;
    chk("t2_cmd_rdy", cmd_rdy, 1);
    step();
    cmd_val = 1'b0;
    chk("t2_busy", busy, 0);
    chk("t2_val", clksel_val, 0);
    step();
    chk("t2_val_later", clksel_val, 0);
    chk("t2_sw", sw_count, 0);

    // Reset during DWELL.
    clksel_rdy = 1'b1;
    cmd_msg = 1'b1; cmd_val = 1'b1;
    step();
    cmd_val = 1'b0;
    step();
    chk("t5b_cur", cur_sel, 1);
    step(); step();
    chk("t5b_in_dwell", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5b_val", clksel_val, 0);
    chk("t5b_cur0", cur_sel, 0);
    chk("t5b_busy", busy, 0);
    chk("t5b_sw", sw_count, 0);
    chk("t5b_rdy", cmd_rdy, 1);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
